rx_frame_parser: RTL
====================

RX_FRAME_PARSER -- requirements
Module: rx_frame_parser

Interface
REQ-001 Parameter FIFO_DEPTH, default 16, payload buffer depth in bytes (power of two, 4 to 256).
REQ-002 Parameter BCAST_EN, default 1, when 1 the destination FF:FF:FF:FF:FF:FF is also accepted.
REQ-003 clk  input  1  clock; all logic on the rising edge.
REQ-004 rst_n  input  1  reset, synchronous, active-low.
REQ-005 local_addr  input  48  station MAC address; byte 0 is bits [47:40].
REQ-006 tdata  input  8  AXI-stream byte from the MAC RX path.
REQ-007 tvalid  input  1  tdata is valid.
REQ-008 tlast  input  1  tdata is the last byte of the frame.
REQ-009 tready  output  1  parser accepts the byte.
REQ-010 rx_data  output  8  payload byte (head of the buffer, first-word-fall-through).
REQ-011 rx_valid  output  1  rx_data is valid (buffer not empty).
REQ-012 rx_ready  input  1  consumer pops the byte.
REQ-013 rx_src_addr  output  48  source address of the current accepted frame.
REQ-014 number_of_bytes  output  16  payload length field of the current accepted frame.
REQ-015 rx_header_valid  output  1  one-cycle pulse when an accepted header completes.
REQ-016 frame_done  output  1  one-cycle pulse when an accepted frame ends with the correct length.
REQ-017 frame_err  output  1  one-cycle pulse on a length or truncation error.

Function
REQ-018 A beat is accepted when tvalid and tready are both 1 on a clock edge.
REQ-019 Frame format: 6-byte destination, 6-byte source, 2-byte length (MSB first), then the payload, with tlast on the final payload byte.
REQ-020 The FSM has states HDR, PAYLOAD and DROP; tready is 1 in HDR and DROP, !buffer_full in PAYLOAD, and 0 while rst_n=0.
REQ-021 HDR: a 4-bit byte counter counts accepted bytes 0..13; header bytes are shifted into the destination, source and length registers.
REQ-022 HDR: tlast on header bytes 0..12 pulses frame_err, clears the counter and keeps the FSM in HDR.
REQ-023 On accepting byte 13, the destination matches if it equals local_addr, or if it is all-ones and BCAST_EN=1.
REQ-024 Byte 13 with no match: go to DROP, or stay in HDR with no pulse if tlast=1.
REQ-025 Byte 13 with a match: pulse rx_header_valid next cycle and update rx_src_addr and number_of_bytes at the same time.
REQ-026 Byte 13 with a match and length 0: tlast=1 gives frame_done and HDR; tlast=0 gives frame_err and DROP.
REQ-027 Byte 13 with a match and length >0: tlast=1 gives frame_err and HDR; otherwise load the 16-bit remaining counter with the length and go to PAYLOAD.
REQ-028 PAYLOAD: each accepted byte is written to the buffer and remaining is decremented.
REQ-029 PAYLOAD with remaining=1: tlast=1 gives frame_done and HDR; tlast=0 gives frame_err and DROP.
REQ-030 PAYLOAD with remaining>1 and tlast=1 gives frame_err and HDR; bytes already buffered are kept.
REQ-031 DROP discards accepted bytes until tlast, then returns to HDR with no pulse.
REQ-032 Buffer: a pop occurs when rx_valid and rx_ready are both 1; a simultaneous push and pop leaves the count unchanged.
REQ-033 Buffer pointers wrap modulo FIFO_DEPTH; the count is one bit wider than the pointers, so full and empty are unambiguous.
REQ-034 Write-to-rx_valid latency is one cycle; no byte is lost or duplicated under any backpressure pattern.
REQ-035 rx_header_valid, frame_done and frame_err are registered, last exactly one cycle, and are never asserted together.

Reset
REQ-036 While rst_n=0 at a clock edge: FSM goes to HDR, counters and buffer pointers clear, and any partial frame is abandoned with no pulse.
REQ-037 Reset values: rx_valid=0, rx_data=0, rx_src_addr=0, number_of_bytes=0, all pulses 0.

Verification
REQ-038 Unicast frame, local_addr=02:00:00:00:00:01, length=4, payload A1 A2 A3 A4, rx_ready=1 -> rx_header_valid once, number_of_bytes=4, A1..A4 in order, frame_done once.
REQ-039 Destination 02:00:00:00:00:99, 20-byte frame -> tready stays 1, no rx_valid, no pulses, FSM back in HDR after tlast.
REQ-040 Broadcast, length=3, with tlast on the 2nd payload byte -> frame_err once, 2 bytes buffered, next frame parsed normally.
REQ-041 FIFO_DEPTH=16, length=40, rx_ready=0 -> tready falls after 16 bytes; releasing rx_ready -> all 40 bytes out in order, frame_done once.
REQ-042 rst_n=0 for one cycle after payload byte 5 of 10 -> buffer empty, outputs at reset values; a following good frame completes correctly.
REQ-043 Length=0 header with tlast on byte 13 -> rx_header_valid then frame_done, no rx_valid.

Source files
------------

// File: rtl/rx_frame_parser.sv
// Ethernet-style RX frame parser: filters on destination MAC, extracts source/length,
// and buffers the payload in a first-word-fall-through FIFO.
module rx_frame_parser #(
  parameter int FIFO_DEPTH = 16,
  parameter bit BCAST_EN   = 1'b1
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [47:0] local_addr,
  input  logic [7:0]  tdata,
  input  logic        tvalid,
  input  logic        tlast,
  output logic        tready,
  output logic [7:0]  rx_data,
  output logic        rx_valid,
  input  logic        rx_ready,
  output logic [47:0] rx_src_addr,
  output logic [15:0] number_of_bytes,
  output logic        rx_header_valid,
  output logic        frame_done,
  output logic        frame_err
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam logic [AW:0] DEPTH_C = (AW + 1)'(FIFO_DEPTH);

  typedef enum logic [1:0] {HDR, PAYLOAD, DROP} state_t;

  state_t         state;
  logic [3:0]     byte_cnt;
  logic [103:0]   hdr_shift;
  logic [15:0]    remaining;
  logic           done_stage;
  logic           err_stage;

  logic [7:0]     mem [FIFO_DEPTH];
  logic [AW-1:0]  wr_ptr;
  logic [AW-1:0]  rd_ptr;
  logic [AW:0]    count;

  logic           buf_full;
  logic           accept;
  logic           push;
  logic           pop;
  logic [47:0]    hdr_dst;
  logic [47:0]    hdr_src;
  logic [15:0]    hdr_len;
  logic           dst_match;

  assign buf_full  = (count == DEPTH_C);
  assign tready    = rst_n && ((state != PAYLOAD) || !buf_full);
  assign accept    = tvalid && tready;
  assign push      = accept && (state == PAYLOAD);
  assign rx_valid  = (count != '0);
  assign pop       = rx_valid && rx_ready;
  assign rx_data   = rx_valid ? mem[rd_ptr] : 8'd0;

  // Bytes 0..12 sit in the shift register; byte 13 completes the length on the fly.
  assign hdr_dst   = hdr_shift[103:56];
  assign hdr_src   = hdr_shift[55:8];
  assign hdr_len   = {hdr_shift[7:0], tdata};
  assign dst_match = (hdr_dst == local_addr) || (BCAST_EN && (&hdr_dst));

  // done/err go through one extra stage so they can never overlap rx_header_valid.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state           <= HDR;
      byte_cnt        <= 4'd0;
      hdr_shift       <= '0;
      remaining       <= 16'd0;
      rx_src_addr     <= 48'd0;
      number_of_bytes <= 16'd0;
      rx_header_valid <= 1'b0;
      done_stage      <= 1'b0;
      err_stage       <= 1'b0;
      frame_done      <= 1'b0;
      frame_err       <= 1'b0;
    end else begin
      rx_header_valid <= 1'b0;
      done_stage      <= 1'b0;
      err_stage       <= 1'b0;
      frame_done      <= done_stage;
      frame_err       <= err_stage;
      if (accept) begin
        case (state)
          HDR: begin
            hdr_shift <= {hdr_shift[95:0], tdata};
            if (byte_cnt != 4'd13) begin
              if (tlast) begin
                err_stage <= 1'b1;
                byte_cnt  <= 4'd0;
              end else begin
                byte_cnt  <= byte_cnt + 4'd1;
              end
            end else begin
              byte_cnt <= 4'd0;
              if (!dst_match) begin
                if (!tlast) state <= DROP;
              end else begin
                rx_header_valid <= 1'b1;
                rx_src_addr     <= hdr_src;
                number_of_bytes <= hdr_len;
                if (hdr_len == 16'd0) begin
                  if (tlast) begin
                    done_stage <= 1'b1;
                  end else begin
                    err_stage  <= 1'b1;
                    state      <= DROP;
                  end
                end else if (tlast) begin
                  err_stage <= 1'b1;
                end else begin
                  remaining <= hdr_len;
                  state     <= PAYLOAD;
                end
              end
            end
          end
          PAYLOAD: begin
            remaining <= remaining - 16'd1;
            if (remaining == 16'd1) begin
              if (tlast) begin
                done_stage <= 1'b1;
                state      <= HDR;
              end else begin
                err_stage  <= 1'b1;
                state      <= DROP;
              end
            end else if (tlast) begin
              err_stage <= 1'b1;
              state     <= HDR;
            end
          end
          DROP: begin
            if (tlast) state <= HDR;
          end
          default: state <= HDR;
        endcase
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= tdata;
  end

endmodule
